// File: rtl/adc_scan_avg.sv
// Multi-channel ADC scan sequencer with per-channel settling, discard and averaging.
// Walks the enabled channels low to high. For each channel it waits the settling
// delay, issues DISCARD + 2^os_log2 conversions to the converter driver, and emits
// the truncated mean of the kept samples.
module adc_scan_avg #(
   parameter int unsigned CLK_PER_US  = 50,
   parameter int unsigned NUM_CH      = 16,
   parameter int unsigned DATA_W      = 12,
   parameter int unsigned MAX_OS_LOG2 = 5,
   parameter int unsigned DISCARD     = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              cont,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic [2:0]        os_log2,
   input  logic [15:0]       dly,
   output logic              drv_start,
   output logic [7:0]        drv_din,
   input  logic [DATA_W-1:0] drv_dout,
   input  logic              drv_done,
   output logic              res_valid,
   output logic [3:0]        res_ch,
   output logic [DATA_W-1:0] res_data,
   output logic              busy,
   output logic              done,
   output logic              scan_wrap
);

   localparam int unsigned AccW  = DATA_W + MAX_OS_LOG2;
   localparam int unsigned CntW  = $clog2(DISCARD + (1 << MAX_OS_LOG2) + 1);
   localparam int unsigned CycW  = $clog2(CLK_PER_US + 1);
   localparam logic [2:0]  OsMax = 3'(MAX_OS_LOG2);

   typedef enum logic [2:0] {StIdle, StSettle, StConv, StWaitc, StNext} state_e;

   state_e            state_q;
   logic [NUM_CH-1:0] mask_q;
   logic [2:0]        os_q;
   logic [15:0]       dly_q;
   logic [3:0]        ch_q;
   logic [CycW-1:0]   cyc_q;
   logic [15:0]       us_q;
   logic [CntW-1:0]   cnt_q;
   logic [AccW-1:0]   acc_q;

   logic              start_found;
   logic [3:0]        start_ch;
   logic [3:0]        lo_ch;
   logic              hi_found;
   logic [3:0]        hi_ch;
   logic [2:0]        os_clamped;
   logic [CntW-1:0]   last_cnt;
   logic [AccW-1:0]   acc_sum;
   logic              settle_end;

   assign busy = (state_q != StIdle);

   // Channel selection: lowest in the incoming mask, lowest and next-higher in the latched one
   always_comb begin
      start_found = 1'b0;
      start_ch    = '0;
      lo_ch       = '0;
      hi_found    = 1'b0;
      hi_ch       = '0;
      // Descending walk so the last hit is the lowest qualifying index
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            start_found = 1'b1;
            start_ch    = 4'(i);
         end
         if (mask_q[i]) begin
            lo_ch = 4'(i);
         end
         if (mask_q[i] && (i > int'(ch_q))) begin
            hi_found = 1'b1;
            hi_ch    = 4'(i);
         end
      end
   end

   // Datapath helpers: clamp, last-conversion index, running sum, settle terminal count
   always_comb begin
      os_clamped = (os_log2 > OsMax) ? OsMax : os_log2;
      last_cnt   = CntW'(DISCARD) + (CntW'(1) << os_q) - CntW'(1);
      // First kept sample restarts the sum instead of adding to a stale value
      acc_sum    = ((cnt_q == CntW'(DISCARD)) ? '0 : acc_q) + AccW'(drv_dout);
      settle_end = (dly_q == 16'd0) ||
                   ((us_q == dly_q - 16'd1) && (cyc_q == CycW'(CLK_PER_US - 1)));
   end

   // Scan FSM with registered handshake and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mask_q    <= '0;
         os_q      <= '0;
         dly_q     <= '0;
         ch_q      <= '0;
         cyc_q     <= '0;
         us_q      <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         drv_start <= 1'b0;
         drv_din   <= '0;
         res_valid <= 1'b0;
         res_ch    <= '0;
         res_data  <= '0;
         done      <= 1'b0;
         scan_wrap <= 1'b0;
      end else begin
         drv_start <= 1'b0;
         res_valid <= 1'b0;
         done      <= 1'b0;
         scan_wrap <= 1'b0;
         if (abort) begin
            // Abort beats everything, including a coincident start
            state_q <= StIdle;
            cnt_q   <= '0;
            cyc_q   <= '0;
            us_q    <= '0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start) begin
                     mask_q <= ch_mask;
                     os_q   <= os_clamped;
                     dly_q  <= dly;
                     cnt_q  <= '0;
                     cyc_q  <= '0;
                     us_q   <= '0;
                     if (start_found) begin
                        ch_q    <= start_ch;
                        state_q <= StSettle;
                     end else begin
                        done <= 1'b1;
                     end
                  end
               end
               StSettle: begin
                  if (settle_end) begin
                     drv_start <= 1'b1;
                     drv_din   <= {ch_q, 4'b0000};
                     state_q   <= StConv;
                  end else if (cyc_q == CycW'(CLK_PER_US - 1)) begin
                     cyc_q <= '0;
                     us_q  <= us_q + 16'd1;
                  end else begin
                     cyc_q <= cyc_q + CycW'(1);
                  end
               end
               StConv: begin
                  state_q <= StWaitc;
               end
               StWaitc: begin
                  if (drv_done) begin
                     cnt_q <= cnt_q + CntW'(1);
                     if (cnt_q >= CntW'(DISCARD)) begin
                        acc_q <= acc_sum;
                     end
                     if (cnt_q == last_cnt) begin
                        res_valid <= 1'b1;
                        res_ch    <= ch_q;
                        res_data  <= DATA_W'(acc_sum >> os_q);
                        cnt_q     <= '0;
                        if (hi_found) begin
                           state_q <= StNext;
                        end else if (cont) begin
                           scan_wrap <= 1'b1;
                           state_q   <= StNext;
                        end else begin
                           done    <= 1'b1;
                           state_q <= StIdle;
                        end
                     end else begin
                        drv_start <= 1'b1;
                        state_q   <= StConv;
                     end
                  end
               end
               StNext: begin
                  // No higher channel left means a continuous-mode wrap to the lowest
                  ch_q    <= hi_found ? hi_ch : lo_ch;
                  cyc_q   <= '0;
                  us_q    <= '0;
                  state_q <= StSettle;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_scan_avg.sv
// Scoreboard bench for adc_scan_avg: directed scans with hand-computed averages,
// a behavioural converter driver and a monitor that checks every result pulse.
module tb_adc_scan_avg;

   typedef struct packed {
      logic [3:0]  ch;
      logic [11:0] data;
      logic        dn;
      logic        wr;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        cont;
   logic [15:0] ch_mask;
   logic [2:0]  os_log2;
   logic [15:0] dly;
   logic        drv_start;
   logic [7:0]  drv_din;
   logic [11:0] drv_dout;
   logic        drv_done;
   logic        res_valid;
   logic [3:0]  res_ch;
   logic [11:0] res_data;
   logic        busy;
   logic        done;
   logic        scan_wrap;

   int   checks = 0;
   int   failures = 0;
   int   n_start = 0;
   int   n_res = 0;
   int   n_done = 0;
   int   default_val = 0;
   int   resp_q[$];
   exp_t exp_q[$];

   adc_scan_avg #(
      .CLK_PER_US (50),
      .NUM_CH     (16),
      .DATA_W     (12),
      .MAX_OS_LOG2(5),
      .DISCARD    (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .cont     (cont),
      .ch_mask  (ch_mask),
      .os_log2  (os_log2),
      .dly      (dly),
      .drv_start(drv_start),
      .drv_din  (drv_din),
      .drv_dout (drv_dout),
      .drv_done (drv_done),
      .res_valid(res_valid),
      .res_ch   (res_ch),
      .res_data (res_data),
      .busy     (busy),
      .done     (done),
      .scan_wrap(scan_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input int ch, input int data, input bit dn, input bit wr);
      exp_t e;
      e.ch   = 4'(ch);
      e.data = 12'(data);
      e.dn   = dn;
      e.wr   = wr;
      exp_q.push_back(e);
   endtask

   // Converter model: answers each drv_start two cycles later with a one-cycle drv_done
   initial begin
      int pend;
      pend     = 0;
      drv_done = 1'b0;
      drv_dout = '0;
      forever begin
         @(negedge clk);
         drv_done = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               drv_dout = (resp_q.size() > 0) ? 12'(resp_q.pop_front()) : 12'(default_val);
               drv_done = 1'b1;
            end
         end
         if (drv_start) begin
            n_start++;
            pend = 2;
         end
      end
   end

   // Monitor: every result pulse must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) n_done++;
         if (res_valid) begin
            n_res++;
            if (exp_q.size() == 0) begin
               check("res_valid_unexpected", int'(res_valid), 0);
            end else begin
               e = exp_q.pop_front();
               check("res_ch", res_ch, e.ch);
               check("res_data", res_data, e.data);
               check("res_done", done, e.dn);
               check("res_wrap", scan_wrap, e.wr);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] m, input logic [2:0] os, input logic [15:0] d);
      ch_mask = m;
      os_log2 = os;
      dly     = d;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Cycles from accepted start to first drv_start, plus the channel it addresses
   task automatic wait_drv_start(input string name, input int exp_lat, input int exp_ch);
      int cnt;
      bit seen;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 2000) begin
         @(negedge clk);
         cnt++;
         if (drv_start) seen = 1'b1;
      end
      check({name, "_latency"}, cnt, exp_lat);
      if (seen) check({name, "_din"}, drv_din, exp_ch * 16);
   endtask

   task automatic wait_idle(input string name);
      int cnt;
      cnt = 0;
      while (busy && cnt < 20000) begin
         @(negedge clk);
         cnt++;
      end
      check({name, "_idle"}, busy, 0);
      tick();
   endtask

   initial begin
      int s0;
      int r0;
      int d0;
      int cnt;
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      cont    = 1'b0;
      ch_mask = '0;
      os_log2 = '0;
      dly     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_drv_start", drv_start, 0);
      check("rst_drv_din", drv_din, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_ch", res_ch, 0);
      check("rst_res_data", res_data, 0);
      check("rst_done", done, 0);
      check("rst_wrap", scan_wrap, 0);
      rst_n = 1'b1;
      tick();

      // Two channels, 3 us settle each, 1 discard + 4 kept; inputs changed after start
      default_val = 100;
      push_exp(0, 100, 1'b0, 1'b0);
      push_exp(2, 100, 1'b1, 1'b0);
      s0 = n_start;
      do_start(16'h0005, 3'd2, 16'd3);
      check("scan_a_busy", busy, 1);
      ch_mask = 16'hFFFF;
      os_log2 = 3'd0;
      dly     = 16'd0;
      wait_drv_start("scan_a_ch0", 151, 0);
      wait_idle("scan_a");
      check("scan_a_starts", n_start - s0, 10);
      check("scan_a_exp_left", exp_q.size(), 0);

      // First sample discarded: (20+30+40+50)>>2 = 35, zero settle delay
      default_val = 0;
      resp_q = '{10, 20, 30, 40, 50};
      push_exp(0, 35, 1'b1, 1'b0);
      do_start(16'h0001, 3'd2, 16'd0);
      wait_drv_start("scan_b_ch0", 2, 0);
      wait_idle("scan_b");
      check("scan_b_exp_left", exp_q.size(), 0);

      // Empty mask: done one cycle after start, never busy, no conversion
      s0 = n_start;
      do_start(16'h0000, 3'd1, 16'd0);
      check("empty_done", done, 1);
      check("empty_busy", busy, 0);
      tick();
      check("empty_done_clear", done, 0);
      check("empty_starts", n_start - s0, 0);

      // Continuous mode on ch0/ch15, wrap once, then stop after ch15
      resp_q = '{7, 111, 7, 222, 7, 333, 7, 444};
      push_exp(0, 111, 1'b0, 1'b0);
      push_exp(15, 222, 1'b0, 1'b1);
      push_exp(0, 333, 1'b0, 1'b0);
      push_exp(15, 444, 1'b1, 1'b0);
      cont = 1'b1;
      r0 = n_res;
      do_start(16'h8001, 3'd0, 16'd0);
      cnt = 0;
      while ((n_res - r0) < 2 && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      check("cont_wrap_seen", n_res - r0, 2);
      cont = 1'b0;
      wait_idle("cont");
      check("cont_exp_left", exp_q.size(), 0);

      // Abort in WAITC with drv_done arriving the cycle after: no result, no done
      default_val = 55;
      s0 = n_start;
      r0 = n_res;
      d0 = n_done;
      do_start(16'h0002, 3'd1, 16'd0);
      wait_drv_start("abort_ch1", 2, 1);
      @(posedge clk);
      #1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      repeat (6) tick();
      check("abort_no_res", n_res - r0, 0);
      check("abort_no_done", n_done - d0, 0);
      check("abort_starts", n_start - s0, 1);
      check("abort_still_idle", busy, 0);

      // Abort and start together: start loses
      abort   = 1'b1;
      start   = 1'b1;
      ch_mask = 16'h0002;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("abort_start_busy", busy, 0);

      // Fresh scan after abort behaves normally
      push_exp(1, 55, 1'b1, 1'b0);
      s0 = n_start;
      do_start(16'h0002, 3'd1, 16'd0);
      wait_drv_start("post_abort_ch1", 2, 1);
      wait_idle("post_abort");
      check("post_abort_starts", n_start - s0, 3);
      check("post_abort_exp_left", exp_q.size(), 0);

      // os_log2=7 clamps to 5: 33 conversions; a start while busy is ignored
      default_val = 4095;
      push_exp(0, 4095, 1'b1, 1'b0);
      s0 = n_start;
      do_start(16'h0001, 3'd7, 16'd0);
      repeat (10) tick();
      do_start(16'h0004, 3'd0, 16'd0);
      wait_idle("clamp");
      check("clamp_starts", n_start - s0, 33);
      check("clamp_exp_left", exp_q.size(), 0);

      // Reset mid-scan clears results; next start begins a fresh scan
      do_start(16'h0001, 3'd0, 16'd1);
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_res_data", res_data, 0);
      check("midrst_drv_start", drv_start, 0);
      tick();
      rst_n = 1'b1;
      tick();
      default_val = 77;
      push_exp(0, 77, 1'b1, 1'b0);
      do_start(16'h0001, 3'd0, 16'd0);
      wait_idle("midrst");
      repeat (3) tick();
      check("midrst_exp_left", exp_q.size(), 0);
      check("res_hold_data", res_data, 77);
      check("res_hold_ch", res_ch, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
